// File: rtl/led_pkg.sv
// Shared types and helpers for the LED nibble display arbiter.
//   state_e  : display FSM states
//   LED_OFF  : all four active-low LEDs dark
//   nib_led  : converts a nibble to active-low LED drive
package led_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHOW_HI = 2'd1,
        SHOW_LO = 2'd2,
        GAP     = 2'd3
    } state_e;

    localparam logic [3:0] LED_OFF = 4'hF;

    function automatic logic [3:0] nib_led(input logic [3:0] nib);
        return ~nib;
    endfunction

endpackage

// File: rtl/led_disp_arb_if.sv
// Byte-source bus shared by NREQ requesters and the display arbiter.
//   req_valid : per-requester byte valid
//   req_data  : byte for requester i at [8i+7:8i]
//   req_ready : one-hot accept strobe from the arbiter
// master = byte sources, slave = arbiter.
interface led_disp_arb_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;

    modport master (output req_valid, output req_data, input req_ready);
    modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter.
//   req : request vector
//   ptr : highest-priority index; search runs upward from here with wrap
//   gnt : one-hot grant (zero when no request)
//   idx : index of the granted requester (zero when no request)
//   any : at least one request present
module rr_arb #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // NOTE: every output gets a default before the search loop so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int off = 0; off < N; off++) begin
            int            j;
            logic [IW-1:0] cand;
            j = int'(ptr) + off;
            if (j >= N) j = j - N;
            cand = IW'(j);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        if (any) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/led_disp_arb.sv
// Time-shares a 4-LED nibble display between NREQ byte sources.
// One byte is accepted per grant (round-robin), shown high nibble then low
// nibble for HALF_CYC cycles each, REPEAT times, followed by GAP_CYC blank
// cycles.
//   sys_clk, rst : clock and asynchronous active-high reset
//   flush        : synchronous abort of the current display
//   bus          : byte-source handshake (slave side)
//   busy         : state != IDLE
//   owner        : index of the requester being displayed
//   lec          : 0 = high nibble shown, 1 = low nibble or blank
//   led          : active-low LED drive
module led_disp_arb
    import led_pkg::*;
#(
    parameter  int NREQ     = 4,
    parameter  int HALF_CYC = 25_000_000,
    parameter  int GAP_CYC  = 5_000_000,
    parameter  int REPEAT   = 1,
    localparam int OW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  flush,
    led_disp_arb_if.slave         bus,
    output logic                  busy,
    output logic [OW-1:0]         owner,
    output logic                  lec,
    output logic [3:0]            led
);

    localparam logic [31:0] HALF_LAST = 32'(HALF_CYC - 1);
    localparam logic [31:0] GAP_LAST  = 32'(GAP_CYC - 1);
    localparam logic [31:0] REP_LAST  = 32'(REPEAT - 1);

    state_e        state_q;
    logic [31:0]   cnt_q;
    logic [31:0]   rep_q;
    logic [7:0]    data_q;
    logic [OW-1:0] ptr_q;
    logic [OW-1:0] owner_q;
    logic          lec_q;
    logic [3:0]    led_q;

    logic [NREQ-1:0] gnt;
    logic [OW-1:0]   g_idx;
    logic            g_any;
    logic [7:0]      sel_byte;
    logic            accept;

    rr_arb #(.N(NREQ)) u_rr_arb (
        .req (bus.req_valid),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (g_idx),
        .any (g_any)
    );

    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (g_idx == OW'(i)) sel_byte = bus.req_data[8*i +: 8];
        end
    end

    // Grants only in IDLE; rst gates ready so it drops the instant reset
    // asserts rather than waiting for the state register.
    assign accept        = (state_q == IDLE) && !flush && g_any;
    assign bus.req_ready = (state_q == IDLE && !flush && !rst) ? gnt : '0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rep_q   <= '0;
            data_q  <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            lec_q   <= 1'b1;
            led_q   <= LED_OFF;
        end else if (flush && state_q != IDLE) begin
            // Abort: pointer keeps the value advanced at accept time.
            state_q <= IDLE;
            cnt_q   <= '0;
            rep_q   <= '0;
            lec_q   <= 1'b1;
            led_q   <= LED_OFF;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        data_q  <= sel_byte;
                        owner_q <= g_idx;
                        ptr_q   <= (g_idx == OW'(NREQ - 1)) ? '0 : g_idx + OW'(1);
                        cnt_q   <= '0;
                        rep_q   <= '0;
                        state_q <= SHOW_HI;
                        lec_q   <= 1'b0;
                        led_q   <= nib_led(sel_byte[7:4]);
                    end
                end
                SHOW_HI: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= '0;
                        state_q <= SHOW_LO;
                        lec_q   <= 1'b1;
                        led_q   <= nib_led(data_q[3:0]);
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                SHOW_LO: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        if (rep_q < REP_LAST) begin
                            rep_q   <= rep_q + 32'd1;
                            state_q <= SHOW_HI;
                            lec_q   <= 1'b0;
                            led_q   <= nib_led(data_q[7:4]);
                        end else if (GAP_CYC > 0) begin
                            state_q <= GAP;
                            lec_q   <= 1'b1;
                            led_q   <= LED_OFF;
                        end else begin
                            state_q <= IDLE;
                            lec_q   <= 1'b1;
                            led_q   <= LED_OFF;
                        end
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy  = (state_q != IDLE);
    assign owner = owner_q;
    assign lec   = lec_q;
    assign led   = led_q;

endmodule

// File: tb/tb_led_disp_arb.sv
// Self-checking bench for led_disp_arb.
// dut_a: NREQ=4, HALF_CYC=4, GAP_CYC=2, REPEAT=1 (scoreboarded grants and
//        run-length display segments).
// dut_b: NREQ=4, HALF_CYC=4, GAP_CYC=0, REPEAT=2 (direct cycle checks).
module tb_led_disp_arb;

    logic       sys_clk = 1'b0;
    logic       rst;
    logic       flush_a, flush_b;
    logic       busy_a, busy_b, lec_a, lec_b;
    logic [1:0] owner_a, owner_b;
    logic [3:0] led_a, led_b;

    led_disp_arb_if #(.NREQ(4)) ifa ();
    led_disp_arb_if #(.NREQ(4)) ifb ();

    led_disp_arb #(.NREQ(4), .HALF_CYC(4), .GAP_CYC(2), .REPEAT(1)) dut_a (
        .sys_clk (sys_clk),
        .rst     (rst),
        .flush   (flush_a),
        .bus     (ifa),
        .busy    (busy_a),
        .owner   (owner_a),
        .lec     (lec_a),
        .led     (led_a)
    );

    led_disp_arb #(.NREQ(4), .HALF_CYC(4), .GAP_CYC(0), .REPEAT(2)) dut_b (
        .sys_clk (sys_clk),
        .rst     (rst),
        .flush   (flush_b),
        .bus     (ifb),
        .busy    (busy_b),
        .owner   (owner_b),
        .lec     (lec_b),
        .led     (led_b)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [5:0] d;    // {busy, lec, led}
        int         len;
    } seg_t;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } gnt_t;

    seg_t seg_q[$];
    gnt_t gnt_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_s(input logic b, input logic l, input logic [3:0] d, input int len);
        seg_t s;
        s.d   = {b, l, d};
        s.len = len;
        seg_q.push_back(s);
    endtask

    task automatic push_g(input int idx, input logic [7:0] data);
        gnt_t g;
        g.idx  = idx;
        g.data = data;
        gnt_q.push_back(g);
    endtask

    task automatic req_a(input int i, input logic [7:0] data);
        ifa.req_data[8*i +: 8] = data;
        ifa.req_valid[i]       = 1'b1;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Requesters on dut_a drop valid right after their accept edge.
    initial begin
        logic [3:0] acc;
        forever begin
            @(negedge sys_clk);
            acc = ifa.req_valid & ifa.req_ready;
            if (acc != 4'b0) begin
                @(posedge sys_clk);
                #1;
                ifa.req_valid = ifa.req_valid & ~acc;
            end
        end
    end

    // Grant monitor: pops the expected grant on every accept strobe and
    // checks owner one cycle later.
    initial begin
        int   own_exp;
        bit   own_pend;
        gnt_t e;
        own_pend = 1'b0;
        own_exp  = 0;
        forever begin
            @(negedge sys_clk);
            if (own_pend) begin
                check("owner", 32'(owner_a), 32'(own_exp));
                own_pend = 1'b0;
            end
            if (ifa.req_ready != 4'b0) begin
                int idx;
                idx = 0;
                for (int i = 3; i >= 0; i--) if (ifa.req_ready[i]) idx = i;
                check("ready_onehot", 32'($onehot(ifa.req_ready)), 32'd1);
                if (gnt_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL grant_unexpected actual=%0d required=none at %0t", idx, $time);
                end else begin
                    e = gnt_q.pop_front();
                    check("grant_idx", 32'(idx), 32'(e.idx));
                    check("grant_data", 32'(ifa.req_data[8*idx +: 8]), 32'(e.data));
                end
                own_pend = 1'b1;
                own_exp  = idx;
            end
        end
    end

    // Segment monitor: run-length encodes {busy,lec,led}; each finished busy
    // run is compared with the next expected segment.
    initial begin
        logic [5:0] cur, now;
        int         len;
        seg_t       e;
        cur = {1'b0, 1'b1, 4'hF};
        len = 0;
        forever begin
            @(negedge sys_clk);
            now = {busy_a, lec_a, led_a};
            if (now == cur) begin
                len++;
            end else begin
                if (cur[5]) begin
                    if (seg_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL seg_unexpected actual=%0h/%0d required=none at %0t", cur, len, $time);
                    end else begin
                        e = seg_q.pop_front();
                        check("seg_disp", 32'(cur), 32'(e.d));
                        check("seg_len", 32'(len), 32'(e.len));
                    end
                end
                cur = now;
                len = 1;
            end
        end
    end

    initial begin
        bit got;
        rst           = 1'b0;
        flush_a       = 1'b0;
        flush_b       = 1'b0;
        ifa.req_valid = '0;
        ifa.req_data  = '0;
        ifb.req_valid = '0;
        ifb.req_data  = '0;
        #1 rst = 1'b1;

        // Reset state.
        @(negedge sys_clk);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_lec", 32'(lec_a), 32'd1);
        check("rst_led", 32'(led_a), 32'hF);
        check("rst_owner", 32'(owner_a), 32'd0);
        check("rst_ready", 32'(ifa.req_ready), 32'd0);
        check("rst_b", 32'({busy_b, lec_b, led_b}), 32'h1F);
        cyc(1);
        rst = 1'b0;

        // dut_b: REPEAT=2, no gap, byte C3.
        ifb.req_data[7:0] = 8'hC3;
        ifb.req_valid     = 4'b0001;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge sys_clk);
            if (ifb.req_ready == 4'b0001) got = 1'b1;
        end
        check("b_grant", 32'(got), 32'd1);
        cyc(1);
        ifb.req_valid = 4'b0000;
        for (int k = 0; k < 16; k++) begin
            @(negedge sys_clk);
            check("b_disp", 32'({busy_b, lec_b, led_b}), ((k / 4) % 2 == 1) ? 32'h3C : 32'h23);
        end
        @(negedge sys_clk);
        check("b_nogap_idle", 32'({busy_b, lec_b, led_b}), 32'h1F);
        cyc(1);

        // Round robin: all four valid, pointer at 0.
        push_g(0, 8'h10); push_s(1, 0, 4'hE, 4); push_s(1, 1, 4'hF, 6);
        push_g(1, 8'h21); push_s(1, 0, 4'hD, 4); push_s(1, 1, 4'hE, 4); push_s(1, 1, 4'hF, 2);
        push_g(2, 8'h32); push_s(1, 0, 4'hC, 4); push_s(1, 1, 4'hD, 4); push_s(1, 1, 4'hF, 2);
        push_g(3, 8'h43); push_s(1, 0, 4'hB, 4); push_s(1, 1, 4'hC, 4); push_s(1, 1, 4'hF, 2);
        req_a(0, 8'h10); req_a(1, 8'h21); req_a(2, 8'h32); req_a(3, 8'h43);
        cyc(48);

        // Second round: 0 and 2 re-request, pointer at 0.
        push_g(0, 8'h5A); push_s(1, 0, 4'hA, 4); push_s(1, 1, 4'h5, 4); push_s(1, 1, 4'hF, 2);
        push_g(2, 8'h6B); push_s(1, 0, 4'h9, 4); push_s(1, 1, 4'h4, 4); push_s(1, 1, 4'hF, 2);
        req_a(0, 8'h5A); req_a(2, 8'h6B);
        cyc(26);

        // Pointer wrap: pointer at 3, requesters 3 and 0.
        push_g(3, 8'h87); push_s(1, 0, 4'h7, 4); push_s(1, 1, 4'h8, 4); push_s(1, 1, 4'hF, 2);
        push_g(0, 8'h78); push_s(1, 0, 4'h8, 4); push_s(1, 1, 4'h7, 4); push_s(1, 1, 4'hF, 2);
        req_a(3, 8'h87); req_a(0, 8'h78);
        cyc(26);

        // Single request A5: busy for 4+4+2 cycles.
        push_g(0, 8'hA5); push_s(1, 0, 4'h5, 4); push_s(1, 1, 4'hA, 4); push_s(1, 1, 4'hF, 2);
        req_a(0, 8'hA5);
        cyc(14);

        // Flush during SHOW_LO, with requester 2 pending.
        push_g(1, 8'h9C); push_s(1, 0, 4'h6, 4); push_s(1, 1, 4'h3, 2);
        push_g(2, 8'hE1); push_s(1, 0, 4'h1, 4); push_s(1, 1, 4'hE, 4); push_s(1, 1, 4'hF, 2);
        req_a(1, 8'h9C);
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge sys_clk);
            if (busy_a) got = 1'b1;
        end
        check("flush_busy_seen", 32'(got), 32'd1);
        req_a(2, 8'hE1);
        cyc(5);
        flush_a = 1'b1;
        cyc(1);
        @(negedge sys_clk);
        check("flush_busy", 32'(busy_a), 32'd0);
        check("flush_lec", 32'(lec_a), 32'd1);
        check("flush_led", 32'(led_a), 32'hF);
        check("flush_blocks_ready", 32'(ifa.req_ready), 32'd0);
        cyc(1);
        flush_a = 1'b0;
        @(negedge sys_clk);
        check("after_flush_ready", 32'(ifa.req_ready), 32'b0100);
        cyc(14);

        // Async reset during SHOW_HI; pointer was 2, restarts at 0.
        push_g(1, 8'h5D); push_s(1, 0, 4'hA, 2);
        push_g(0, 8'h4E); push_s(1, 0, 4'hB, 4); push_s(1, 1, 4'h1, 4); push_s(1, 1, 4'hF, 2);
        push_g(2, 8'h6F); push_s(1, 0, 4'h9, 4); push_s(1, 1, 4'h0, 4); push_s(1, 1, 4'hF, 2);
        req_a(1, 8'h5D);
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge sys_clk);
            if (busy_a) got = 1'b1;
        end
        check("arst_busy_seen", 32'(got), 32'd1);
        req_a(0, 8'h4E); req_a(2, 8'h6F);
        cyc(1);
        @(posedge sys_clk);
        #3 rst = 1'b1;
        #1;
        check("arst_lec", 32'(lec_a), 32'd1);
        check("arst_led", 32'(led_a), 32'hF);
        check("arst_busy", 32'(busy_a), 32'd0);
        check("arst_owner", 32'(owner_a), 32'd0);
        check("arst_ready", 32'(ifa.req_ready), 32'd0);
        cyc(2);
        rst = 1'b0;
        cyc(26);

        check("grant_q_empty", 32'(gnt_q.size()), 32'd0);
        check("seg_q_empty", 32'(seg_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
